// File: rtl/io_hub_if.sv
// CPU data-port bundle between the processor and io_hub.
// The CPU drives address/data/strobes; the hub returns register read data.
interface io_hub_if;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        wr;
    logic        rd;
    logic [3:0]  wr_mask;
    logic [31:0] mrd;
    logic        mrd_valid;

    modport master (
        output addr_in, data_in, wr, rd, wr_mask,
        input  mrd, mrd_valid
    );

    modport slave (
        input  addr_in, data_in, wr, rd, wr_mask,
        output mrd, mrd_valid
    );
endinterface

// File: rtl/io_hub.sv
// CPU I/O hub: region decode for RAM/VGA strobes plus a memory-mapped block
// holding a prescaled timer, keyboard RX FIFO and interrupt pending/enable masks.
module io_hub #(
    parameter logic [3:0] IO_REGION   = 4'hE,
    parameter logic [3:0] VGA_REGION  = 4'h1,
    parameter logic [3:0] RAM_REGION  = 4'h0,
    parameter int         FIFO_DEPTH  = 16,
    parameter int         NUM_EXT_IRQ = 2,
    parameter int         TICK_DIV    = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    io_hub_if.slave                bus,
    input  logic [7:0]             kb_data,
    input  logic                   kb_valid,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq,
    output logic                   ram_en,
    output logic                   vga_wr,
    output logic                   irq
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int NIRQ = NUM_EXT_IRQ + 2;
    localparam int PW   = $clog2(TICK_DIV) + 1;

    localparam logic [5:0] OFF_TCOUNT = 6'h00;
    localparam logic [5:0] OFF_TCMP   = 6'h01;
    localparam logic [5:0] OFF_TCTRL  = 6'h02;
    localparam logic [5:0] OFF_KBDATA = 6'h03;
    localparam logic [5:0] OFF_KBSTAT = 6'h04;
    localparam logic [5:0] OFF_IPEND  = 6'h05;
    localparam logic [5:0] OFF_IEN    = 6'h06;

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
        return r;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  m);
        logic [31:0] bm;
        bm = byte_mask(m);
        return (old_v & ~bm) | (new_v & bm);
    endfunction

    function automatic logic [31:0] kb_status(input logic emp, input logic ful,
                                              input logic ov, input logic [7:0] cnt);
        return {16'h0000, cnt, 5'b00000, ov, ful, emp};
    endfunction

    logic [31:0]   tcount, tcmp;
    logic          t_en, t_ar;
    logic [PW-1:0] pre;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          ovf;
    logic          ipend_tmr;
    logic [NUM_EXT_IRQ-1:0] ipend_ext;
    logic [NIRQ-1:0] ien;

    logic [3:0]  region;
    logic [5:0]  offset;
    logic        io_acc, wr_io, rd_io;
    logic        empty, full;
    logic [NIRQ-1:0] ipend;
    logic        tick, tmatch;
    logic [31:0] tinc;
    logic        pop, push, drop;
    logic [31:0] rd_data;
    logic [31:0] tctrl_wr, ien_wr, w1c_all;

    assign region = bus.addr_in[31:28];
    assign offset = bus.addr_in[7:2];
    assign io_acc = (region == IO_REGION);
    assign wr_io  = bus.wr && io_acc;
    assign rd_io  = bus.rd && io_acc;
    assign ram_en = bus.wr && (region == RAM_REGION);
    assign vga_wr = bus.wr && (region == VGA_REGION);

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    // FIFO-not-empty is a live level, so it never occupies a sticky flop.
    assign ipend = {ipend_ext, ~empty, ipend_tmr};

    assign tick   = t_en && (pre == PW'(TICK_DIV - 1));
    assign tinc   = tcount + 32'd1;
    assign tmatch = tick && (tinc == tcmp);

    // A pop at full frees the slot the same-cycle push lands in.
    assign pop  = rd_io && (offset == OFF_KBDATA) && !empty;
    assign push = kb_valid && (!full || pop);
    assign drop = kb_valid && full && !pop;

    assign tctrl_wr = merge_bytes({30'b0, t_ar, t_en}, bus.data_in, bus.wr_mask);
    assign ien_wr   = merge_bytes(32'(ien), bus.data_in, bus.wr_mask);
    assign w1c_all  = (wr_io && offset == OFF_IPEND) ?
                      (bus.data_in & byte_mask(bus.wr_mask)) : 32'h0;

    always_comb begin
        rd_data = 32'h0;
        case (offset)
            OFF_TCOUNT: rd_data = tcount;
            OFF_TCMP:   rd_data = tcmp;
            OFF_TCTRL:  rd_data = {30'b0, t_ar, t_en};
            OFF_KBDATA: rd_data = empty ? 32'h0 : 32'(mem[head]);
            OFF_KBSTAT: rd_data = kb_status(empty, full, ovf, 8'(count));
            OFF_IPEND:  rd_data = 32'(ipend);
            OFF_IEN:    rd_data = 32'(ien);
            default:    rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= kb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcount        <= '0;
            tcmp          <= '0;
            t_en          <= 1'b0;
            t_ar          <= 1'b0;
            pre           <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ovf           <= 1'b0;
            ipend_tmr     <= 1'b0;
            ipend_ext     <= '0;
            ien           <= '0;
            bus.mrd       <= '0;
            bus.mrd_valid <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (!t_en || tick) pre <= '0;
            else               pre <= pre + PW'(1);

            if (tick) begin
                if (tmatch) begin
                    tcount <= t_ar ? 32'h0 : tcmp;
                    if (!t_ar) t_en <= 1'b0;
                end else begin
                    tcount <= tinc;
                end
            end

            // CPU writes land after the timer update so they take precedence.
            if (wr_io) begin
                case (offset)
                    OFF_TCOUNT: tcount <= merge_bytes(tcount, bus.data_in, bus.wr_mask);
                    OFF_TCMP:   tcmp   <= merge_bytes(tcmp, bus.data_in, bus.wr_mask);
                    OFF_TCTRL:  {t_ar, t_en} <= tctrl_wr[1:0];
                    OFF_IEN:    ien    <= ien_wr[NIRQ-1:0];
                    default:    ;
                endcase
            end

            ipend_tmr <= (ipend_tmr & ~w1c_all[0]) | tmatch;
            ipend_ext <= (ipend_ext & ~w1c_all[NIRQ-1:2]) | ext_irq;

            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (drop)                                ovf <= 1'b1;
            else if (wr_io && offset == OFF_KBSTAT)  ovf <= 1'b0;

            bus.mrd_valid <= rd_io;
            if (rd_io) bus.mrd <= rd_data;

            irq <= |(ipend & ien);
        end
    end

    wire unused_ok = &{1'b0, bus.addr_in, tctrl_wr, ien_wr, w1c_all};
endmodule

// File: doc/io_hub.md
Name: io_hub

Overview:
- Parametrised successor of the CPU I/O controller: decodes the 32-bit data bus into regions and strobes RAM and VGA writes.
- Adds memory-mapped I/O registers for a prescaled timer, a keyboard RX FIFO and an interrupt controller with pending/enable masks.
- Sits between the CPU data port and the peripherals; the display module and game ROM stay external and are strobed from here.

Parameters:
- IO_REGION, 4'hE, value of addr_in[31:28] selecting the register block.
- VGA_REGION, 4'h1, value of addr_in[31:28] selecting display writes.
- RAM_REGION, 4'h0, value of addr_in[31:28] selecting RAM writes.
- FIFO_DEPTH, 16, keyboard FIFO entries; power of two, 2..256.
- NUM_EXT_IRQ, 2, external level-sensitive interrupt inputs, 1..30.
- TICK_DIV, 50000, clk cycles per timer tick (1 ms at 50 MHz); must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- addr_in  in  32  CPU data address.
- data_in  in  32  CPU write data.
- wr  in  1  write strobe.
- rd  in  1  read strobe.
- wr_mask  in  4  byte enables for data_in[8k+7:8k].
- kb_data  in  8  ASCII byte from keyboard decoder.
- kb_valid  in  1  one-cycle push strobe for kb_data.
- ext_irq  in  NUM_EXT_IRQ  external interrupt levels.
- ram_en  out  1  RAM write enable.
- vga_wr  out  1  display write enable.
- mrd  out  32  register read data.
- mrd_valid  out  1  mrd qualifier.
- irq  out  1  CPU interrupt request.

Behaviour:
- Clocking: everything on rising clk. Reset is synchronous and active-high.
- Reset values: all registers, FIFO pointers/count, prescaler, mrd, mrd_valid and irq clear to 0.
- Decode (combinational):
  - ram_en = wr & region==RAM_REGION.
  - vga_wr = wr & region==VGA_REGION.
  - IO access = region==IO_REGION; offset = addr_in[7:2]. Unmapped offsets read 0; writes to them are ignored.
- Register map (byte offset):
  - 0x00 TCOUNT R/W.
  - 0x04 TCMP R/W.
  - 0x08 TCTRL [0]=enable, [1]=auto-reload.
  - 0x0C KBDATA R, pops the FIFO.
  - 0x10 KBSTAT R: [0]=empty, [1]=full, [2]=overflow, [15:8]=count. Any write clears overflow.
  - 0x14 IPEND R, W1C.
  - 0x18 IEN R/W.
- Writes honour wr_mask per byte.
- Reads: rd in IO region registers mrd next cycle with mrd_valid=1 for one cycle (latency 1). Otherwise mrd_valid=0 and mrd holds its value. wr and rd in the same cycle: the write is applied first, then the read returns the pre-write value.
- Timer:
  - Prescaler counts 0..TICK_DIV-1 while enable=1; it resets to 0 when enable=0.
  - On prescaler wrap, TCOUNT increments modulo 2^32.
  - When an increment would make TCOUNT==TCMP: IPEND[0] sets; TCOUNT becomes 0 if auto-reload, else it holds TCMP and enable clears.
  - A CPU write to TCOUNT in the same cycle overrides the increment.
- FIFO: circular buffer of FIFO_DEPTH bytes.
  - Push on kb_valid when not full.
  - Push when full: byte dropped, overflow set (sticky).
  - Pop on KBDATA read: returns the head byte. Pop when empty returns 0 and changes no state.
  - Push and pop in the same cycle: both happen and count is unchanged. When full, the pop frees the slot and the push succeeds. When empty, only the push happens and the read returns 0.
- Interrupts:
  - IPEND[0]=timer (sticky).
  - IPEND[1]=FIFO non-empty (level, not clearable by W1C).
  - IPEND[2+i]=ext_irq[i] (sticky, set while high).
  - W1C on a bit in the same cycle as its set event: set wins.
  - irq is registered: irq = |(IPEND & IEN), one cycle after the pending change.
- Reset mid-operation: reset has priority over every event in that cycle. The FIFO empties; pending read data is lost with mrd_valid=0.

Test Plan:
- Reset, then read KBSTAT: mrd=0x00000001 one cycle after rd; irq=0.
- TICK_DIV=2, TCMP=3, TCTRL=3, IEN=1: after 6 cycles IPEND[0]=1 and irq=1 one cycle later; TCOUNT=0. Writing IPEND=1 clears irq next cycle.
- Push 0x41,0x42, then read KBDATA twice: 0x41 then 0x42; KBSTAT then reads 0x00000001. A third read returns 0.
- Push FIFO_DEPTH+1 bytes: KBSTAT reads full=1, overflow=1, count=FIFO_DEPTH. Simultaneous pop+push at full leaves count=FIFO_DEPTH. A write to KBSTAT clears overflow.
- wr to 0x1000_0010: vga_wr=1, ram_en=0. wr to 0x0000_0010: ram_en=1. Write 0xFFFFFFFF to TCMP with wr_mask=4'b0011 reads back 0x0000FFFF.
- With ext_irq[0] held high, W1C IPEND[2]: bit stays set. Assert reset during a pending read: mrd_valid=0 and irq=0 next cycle.
